// File: rtl/ha_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ha_share_arbiter
// Brief    : Round-robin sharing of one pipelined half adder among NREQ
//            requesters, with a tag pipe that routes results back to owners.
//            Optional macro HA_ARB_STATS_EN adds op_count / stats_clr.
// Revision : 1.0 - initial release
// ============================================================================
module ha_share_arbiter #(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int HA_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_a,
    input  logic [NREQ-1:0] req_b,
    output logic [NREQ-1:0] req_ready,
    output logic            ha_a,
    output logic            ha_b,
    input  logic            ha_s,
    input  logic            ha_cout,
    output logic            resp_valid,
    output logic            resp_s,
    output logic            resp_cout,
    output logic [IDW-1:0]  resp_id,
    output logic            busy
`ifdef HA_ARB_STATS_EN
    ,
    output logic [15:0]     op_count,
    input  logic            stats_clr
`endif
);

    localparam int c_nstg = HA_LAT + 1;

    logic [IDW-1:0]  r_ptr;
    logic            r_ha_a;
    logic            r_ha_b;
    logic [c_nstg-1:0] r_tv;
    logic [IDW-1:0]  r_tid [c_nstg];
    logic            r_resp_valid;
    logic            r_resp_s;
    logic            r_resp_cout;
    logic [IDW-1:0]  r_resp_id;

    logic            w_found;
    logic [IDW-1:0]  w_gid;
    logic [NREQ-1:0] w_sel;
    logic            w_a;
    logic            w_b;
    logic            w_acc;
    logic [IDW-1:0]  w_ptr_nxt;

    // Search order is ptr, ptr+1, ... wrapping; the first valid hit wins.
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_sel   = '0;
        w_a     = 1'b0;
        w_b     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_found && req_valid[i] && (i == (int'(r_ptr) + k) % NREQ)) begin
                    w_found  = 1'b1;
                    w_gid    = IDW'(i);
                    w_sel[i] = 1'b1;
                    w_a      = req_a[i];
                    w_b      = req_b[i];
                end
            end
        end
    end

    assign w_acc     = w_found & en & rst;
    assign req_ready = (en && rst) ? w_sel : '0;
    assign w_ptr_nxt = (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr  <= '0;
            r_ha_a <= 1'b0;
            r_ha_b <= 1'b0;
        end else if (w_acc) begin
            r_ptr  <= w_ptr_nxt;
            r_ha_a <= w_a;
            r_ha_b <= w_b;
        end
    end

    // Tag pipe shifts every cycle; the adder never stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tv <= '0;
            for (int k = 0; k < c_nstg; k++) begin
                r_tid[k] <= '0;
            end
        end else begin
            r_tv     <= {r_tv[c_nstg-2:0], w_acc};
            r_tid[0] <= w_gid;
            for (int k = 1; k < c_nstg; k++) begin
                r_tid[k] <= r_tid[k-1];
            end
        end
    end

    // The last tag stage lines up with the adder output being valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_valid <= 1'b0;
            r_resp_s     <= 1'b0;
            r_resp_cout  <= 1'b0;
            r_resp_id    <= '0;
        end else begin
            r_resp_valid <= r_tv[HA_LAT];
            if (r_tv[HA_LAT]) begin
                r_resp_s    <= ha_s;
                r_resp_cout <= ha_cout;
                r_resp_id   <= r_tid[HA_LAT];
            end
        end
    end

    assign ha_a       = r_ha_a;
    assign ha_b       = r_ha_b;
    assign resp_valid = r_resp_valid;
    assign resp_s     = r_resp_s;
    assign resp_cout  = r_resp_cout;
    assign resp_id    = r_resp_id;
    assign busy       = |r_tv;

`ifdef HA_ARB_STATS_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_count <= '0;
        end else if (stats_clr) begin
            r_op_count <= '0;
        end else if (w_acc && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule
`default_nettype wire

// File: doc/ha_share_arbiter.md
Name: ha_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one pipelined half-adder unit among NREQ requesters.
- Accepts at most one operand pair per cycle and drives it into the half adder.
- Tracks each operation through the adder's fixed pipeline latency with a tag pipe.
- Returns each sum/carry to the originating requester with its ID.
- Sits between the requesting logic and the pipelined half adder, which it instantiates nowhere; the adder is wired externally.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of resp_id; must satisfy 2**IDW >= NREQ.
- HA_LAT, 1, clock cycles from a registered ha_a/ha_b change to a valid ha_s/ha_cout (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- en  in  1  issue enable; 0 blocks new grants, in-flight ops still drain.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ  per-requester operand A (bit i belongs to requester i).
- req_b  in  NREQ  per-requester operand B.
- req_ready  out  NREQ  one-hot grant; transfer on req_valid[i] & req_ready[i].
- ha_a  out  1  registered operand A to the half adder.
- ha_b  out  1  registered operand B to the half adder.
- ha_s  in  1  half-adder sum.
- ha_cout  in  1  half-adder carry.
- resp_valid  out  1  one-cycle result pulse.
- resp_s  out  1  returned sum.
- resp_cout  out  1  returned carry.
- resp_id  out  IDW  index of the requester that owns the result.
- busy  out  1  high while any op is in flight.

Behaviour:
- Reset (rst=0, async):
  - ha_a, ha_b, resp_valid, resp_s, resp_cout, resp_id, busy all 0.
  - Tag pipe cleared; RR pointer = 0.
  - req_ready is 0 while rst=0.
- Arbitration:
  - req_ready is combinational from req_valid, en and the pointer ptr.
  - Grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, ... wrapping mod NREQ.
  - req_ready is all zero when en=0 or no request is valid.
  - At most one bit of req_ready is set.
- Pointer update:
  - On an accept by requester g at edge E, ptr <= (g+1) mod NREQ.
  - No accept means ptr holds.
  - Guarantee: a continuously valid requester waits at most NREQ-1 grants.
- Issue:
  - On accept at edge E: ha_a <= req_a[g], ha_b <= req_b[g].
  - Tag stage 0 <= {valid=1, id=g}.
  - No accept: ha_a/ha_b hold their value, and tag stage 0 valid <= 0.
- Tag pipe:
  - HA_LAT+1 stages, shifting every cycle unconditionally.
  - No backpressure; the adder pipeline never stalls.
- Response:
  - An op accepted at edge E produces resp_valid=1 after edge E+HA_LAT+1, for exactly one cycle.
  - resp_s and resp_cout are sampled from ha_s/ha_cout at that edge; resp_id = g.
  - Total latency = HA_LAT+1 cycles; throughput = 1 op/cycle.
  - Results return in issue order.
- Idle outputs: when resp_valid=0, resp_s, resp_cout and resp_id hold their last values.
- busy = OR of all tag-pipe valid bits.
- Boundary conditions:
  - All NREQ valid every cycle: grants rotate 0,1,2,3,0,...
  - en deasserted mid-burst: issuance stops next cycle; ops already accepted still return.
  - Single requester valid continuously: granted every cycle regardless of ptr.
  - Reset asserted mid-operation: all in-flight ops are discarded; no resp_valid is produced for them after release.
  - The first grant after release searches from ptr=0.
  - req_valid dropping without ready: no transfer and no state change.

Optional Feature:
- Macro HA_ARB_STATS_EN.
- When defined:
  - Adds output port op_count (16 bits).
  - op_count increments on every accept and saturates at 16'hFFFF.
  - Reset value 0.
  - Adds input stats_clr (1 bit); stats_clr=1 zeroes op_count synchronously, taking priority over an increment in the same cycle.
- When undefined: neither port exists and no counter logic is generated; all other behaviour is identical.

Test Plan:
- Reset: rst=0 with all req_valid=1 -> req_ready=0, resp_valid=0, busy=0, ha_a=ha_b=0. Release rst -> first grant is req_ready=4'b0001.
- Single requester: requester 2 valid, a=1, b=1, HA_LAT=1 -> accept at edge E; resp_valid=1 after E+2 with resp_s=0, resp_cout=1, resp_id=2.
- Full contention: all 4 valid for 8 cycles, operand pairs cycling 00/01/10/11 -> grant order 0,1,2,3,0,1,2,3.
  - Responses arrive in the same order with (s,cout) = (0,0), (1,0), (1,0), (0,1).
- Fairness: requesters 1 and 3 always valid, 0 and 2 idle -> grants alternate 1,3,1,3; neither waits more than 1 grant.
- Enable and drain: assert en=0 after 2 accepts -> req_ready=0 immediately; the 2 pending responses still arrive, then busy falls to 0.
- Reset mid-flight: pull rst low 1 cycle after an accept -> no resp_valid after release; ptr=0. With HA_ARB_STATS_EN defined: 5 accepts -> op_count=5; stats_clr pulse -> 0.
